// File: rtl/dmem_port_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_port_pkg
// Description : Shared definitions for the memory-stage data-memory port.
//               Access size codes (funct3[1:0]) and FSM state encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_port_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } dmem_state_e;

endpackage : dmem_port_pkg
`default_nettype wire

// File: rtl/dmem_port_store_align.sv
`default_nettype none
// ============================================================================
// Module      : store_align
// Description : Combinational byte-lane steering for stores.
//               size + addr[1:0] + LSB-aligned data -> byte enables and
//               lane-replicated write data. Size 2'b11 behaves as word.
// Ports       : size[1:0]  in  access size code
//               addr[1:0]  in  byte offset within the word
//               wd[31:0]   in  LSB-aligned store data
//               be[3:0]    out byte enables
//               wdata[31:0] out replicated write data
//               misaligned out (only with DMEM_MISALIGN_TRAP_EN) half at odd
//                          offset or word at non-zero offset
// Config      : DMEM_MISALIGN_TRAP_EN adds the misaligned output.
// Revision    : 1.0 - initial release
// ============================================================================
module store_align
  import dmem_port_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr,
  input  logic [31:0] wd,
  output logic [3:0]  be,
  output logic [31:0] wdata
`ifdef DMEM_MISALIGN_TRAP_EN
  ,
  output logic        misaligned
`endif
);

  always_comb begin
    be    = 4'b1111;
    wdata = wd;
    unique case (size)
      SZ_BYTE: begin
        be    = 4'b0001 << addr;
        wdata = {4{wd[7:0]}};
      end
      SZ_HALF: begin
        // Halfword lane chosen by addr[1] only; addr[0] never shifts it.
        be    = 4'b0011 << {addr[1], 1'b0};
        wdata = {2{wd[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wdata = wd;
      end
    endcase
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  always_comb begin
    misaligned = 1'b0;
    if (size == SZ_HALF)
      misaligned = addr[0];
    else if (size != SZ_BYTE)
      misaligned = (addr != 2'b00);
  end
`endif

endmodule : store_align
`default_nettype wire

// File: rtl/dmem_port.sv
`default_nettype none
// ============================================================================
// Module      : dmem_port
// Description : Memory-stage data-memory access unit. Launches one req/ack
//               bus transfer per M-stage load/store, stalls the pipeline while
//               it is in flight, and returns the raw aligned read word.
// Ports       : clk, reset (sync, active-high)
//               MemReadM, MemWriteM, InstrM_2b[1:0], ALUResultM[31:0],
//               WriteDataM[31:0]                  - M-stage inputs
//               MemDataM[31:0], StallMem          - to datapath
//               bus_req, bus_we, bus_addr[31:0], bus_wdata[31:0], bus_be[3:0],
//               bus_ack, bus_rdata[31:0]          - data bus
//               bus_timeout                       - abort pulse
//               misalign_err (DMEM_MISALIGN_TRAP_EN only)
// Config      : DMEM_MISALIGN_TRAP_EN - trap misaligned half/word accesses
//               instead of issuing them to the bus.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_port
  import dmem_port_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [1:0]  InstrM_2b,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] MemDataM,
  output logic        StallMem,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        bus_timeout
`ifdef DMEM_MISALIGN_TRAP_EN
  ,
  output logic        misalign_err
`endif
);

  localparam int         CW      = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  dmem_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          we_q, we_d;
  logic [3:0]    be_q, be_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   mem_data_q, mem_data_d;
  logic          timeout_q, timeout_d;

  logic [3:0]    align_be;
  logic [31:0]   align_wdata;
  logic          access;

`ifdef DMEM_MISALIGN_TRAP_EN
  logic          align_mis;
`endif

  store_align u_store_align (
    .size       (InstrM_2b),
    .addr       (ALUResultM[1:0]),
    .wd         (WriteDataM),
    .be         (align_be),
    .wdata      (align_wdata)
`ifdef DMEM_MISALIGN_TRAP_EN
    ,
    .misaligned (align_mis)
`endif
  );

  assign access = MemReadM | MemWriteM;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    be_d       = be_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    mem_data_d = mem_data_q;
    timeout_d  = 1'b0;
    StallMem   = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
    misalign_err = 1'b0;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (access) begin
          StallMem = 1'b1;
          cnt_d    = '0;
`ifdef DMEM_MISALIGN_TRAP_EN
          if (align_mis) begin
            misalign_err = 1'b1;
            state_d      = ST_DONE;
          end else
`endif
          begin
            state_d = ST_REQ;
            // Read+write together is a write; reads always fetch the whole word.
            we_d    = MemWriteM;
            be_d    = MemWriteM ? align_be : 4'b1111;
            addr_d  = {ALUResultM[31:2], 2'b00};
            wdata_d = align_wdata;
          end
        end
      end

      ST_REQ: begin
        StallMem = 1'b1;
        // Ack is checked first so a last-cycle ack beats the timeout.
        if (bus_ack) begin
          if (!we_q)
            mem_data_d = bus_rdata;
          state_d = ST_DONE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          mem_data_d = '0;
          timeout_d  = 1'b1;
          state_d    = ST_DONE;
          cnt_d      = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ST_DONE: begin
        // Pipeline advances at this edge; M-stage inputs still show the
        // finished access, so they are deliberately not sampled here.
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      we_q       <= 1'b0;
      be_q       <= 4'b0000;
      addr_q     <= '0;
      wdata_q    <= '0;
      mem_data_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      we_q       <= we_d;
      be_q       <= be_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      mem_data_q <= mem_data_d;
      timeout_q  <= timeout_d;
    end
  end

  assign bus_req     = (state_q == ST_REQ);
  assign bus_we      = we_q;
  assign bus_be      = be_q;
  assign bus_addr    = addr_q;
  assign bus_wdata   = wdata_q;
  assign MemDataM    = mem_data_q;
  assign bus_timeout = timeout_q;

endmodule : dmem_port
`default_nettype wire

// File: tb/tb_dmem_port.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_port
// Description : Directed self-checking bench for dmem_port.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_port;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemReadM, MemWriteM;
  logic [1:0]  InstrM_2b;
  logic [31:0] ALUResultM, WriteDataM;
  logic [31:0] MemDataM;
  logic        StallMem;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        bus_timeout;
`ifdef DMEM_MISALIGN_TRAP_EN
  logic        misalign_err;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dmem_port #(.TIMEOUT_CYCLES(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .MemReadM    (MemReadM),
    .MemWriteM   (MemWriteM),
    .InstrM_2b   (InstrM_2b),
    .ALUResultM  (ALUResultM),
    .WriteDataM  (WriteDataM),
    .MemDataM    (MemDataM),
    .StallMem    (StallMem),
    .bus_req     (bus_req),
    .bus_we      (bus_we),
    .bus_addr    (bus_addr),
    .bus_wdata   (bus_wdata),
    .bus_be      (bus_be),
    .bus_ack     (bus_ack),
    .bus_rdata   (bus_rdata),
    .bus_timeout (bus_timeout)
`ifdef DMEM_MISALIGN_TRAP_EN
    ,
    .misalign_err(misalign_err)
`endif
  );

  // Transaction record filled by run_access
  int          t_stalls, t_reqs;
  logic [3:0]  t_be;
  logic [31:0] t_addr, t_wdata, t_md;
  logic        t_we, t_idle_req, t_done_req, t_done_to, t_early_to;

  // Drives one access starting from an IDLE/DONE cycle; returns in the DONE
  // cycle with the M-stage inputs still asserted. ack_at = REQ cycle (1-based)
  // in which bus_ack is pulsed, 0 = never.
  task automatic run_access(input logic rd, input logic wr, input logic [1:0] sz,
                            input logic [31:0] addr, input logic [31:0] wd,
                            input int ack_at, input logic [31:0] rdata);
    @(posedge clk); #1;
    MemReadM = rd; MemWriteM = wr; InstrM_2b = sz;
    ALUResultM = addr; WriteDataM = wd; bus_rdata = rdata; bus_ack = 1'b0;
    #1;
    t_stalls = StallMem ? 1 : 0;
    t_idle_req = bus_req;
    t_reqs = 0;
    t_early_to = 1'b0;
    t_be = 'x; t_addr = 'x; t_wdata = 'x; t_we = 1'bx;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      bus_ack = 1'b0;
      if (!StallMem) break;
      t_reqs++;
      t_stalls++;
      if (t_reqs == 1) begin
        t_be = bus_be; t_addr = bus_addr; t_wdata = bus_wdata; t_we = bus_we;
      end
      if (bus_timeout) t_early_to = 1'b1;
      if (t_reqs == ack_at) bus_ack = 1'b1;
    end
    t_done_req = bus_req;
    t_done_to  = bus_timeout;
    t_md       = MemDataM;
  endtask

  task automatic clear_inputs();
    MemReadM = 1'b0; MemWriteM = 1'b0; InstrM_2b = 2'b00;
    ALUResultM = '0; WriteDataM = '0; bus_ack = 1'b0; bus_rdata = '0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    n_cmp++; if (bus_req !== 1'b0) begin n_bad++; $display("FAIL reset_req: got %b want 0", bus_req); end
    n_cmp++; if (bus_we !== 1'b0) begin n_bad++; $display("FAIL reset_we: got %b want 0", bus_we); end
    n_cmp++; if (bus_be !== 4'b0000) begin n_bad++; $display("FAIL reset_be: got %b want 0000", bus_be); end
    n_cmp++; if (MemDataM !== 32'h0) begin n_bad++; $display("FAIL reset_memdata: got %h want 0", MemDataM); end
    n_cmp++; if (bus_timeout !== 1'b0) begin n_bad++; $display("FAIL reset_timeout: got %b want 0", bus_timeout); end
    n_cmp++; if (StallMem !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %b want 0", StallMem); end
  endtask

  task automatic test_store();
    // sw 0xDEADBEEF @0x100, ack in third REQ cycle
    run_access(1'b0, 1'b1, 2'b10, 32'h100, 32'hDEADBEEF, 3, 32'h0);
    n_cmp++; if (t_be !== 4'b1111) begin n_bad++; $display("FAIL sw_be: got %b want 1111", t_be); end
    n_cmp++; if (t_addr !== 32'h100) begin n_bad++; $display("FAIL sw_addr: got %h want 00000100", t_addr); end
    n_cmp++; if (t_we !== 1'b1) begin n_bad++; $display("FAIL sw_we: got %b want 1", t_we); end
    n_cmp++; if (t_wdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL sw_wdata: got %h want deadbeef", t_wdata); end
    n_cmp++; if (t_stalls !== 4) begin n_bad++; $display("FAIL sw_stall_cycles: got %0d want 4", t_stalls); end
    n_cmp++; if (t_md !== 32'h0) begin n_bad++; $display("FAIL sw_memdata: got %h want 0", t_md); end
    // sb 0xA5 @0x103
    run_access(1'b0, 1'b1, 2'b00, 32'h103, 32'h000000A5, 1, 32'h0);
    n_cmp++; if (t_be !== 4'b1000) begin n_bad++; $display("FAIL sb_be: got %b want 1000", t_be); end
    n_cmp++; if (t_wdata !== 32'hA5A5A5A5) begin n_bad++; $display("FAIL sb_wdata: got %h want a5a5a5a5", t_wdata); end
    n_cmp++; if (t_addr !== 32'h100) begin n_bad++; $display("FAIL sb_addr: got %h want 00000100", t_addr); end
    // sh 0xBEEF @0x102
    run_access(1'b0, 1'b1, 2'b01, 32'h102, 32'h0000BEEF, 1, 32'h0);
    n_cmp++; if (t_be !== 4'b1100) begin n_bad++; $display("FAIL sh_be: got %b want 1100", t_be); end
    n_cmp++; if (t_wdata !== 32'hBEEFBEEF) begin n_bad++; $display("FAIL sh_wdata: got %h want beefbeef", t_wdata); end
    clear_inputs();
  endtask

  task automatic test_load();
    run_access(1'b1, 1'b0, 2'b10, 32'h204, 32'h0, 1, 32'h12345678);
    n_cmp++; if (t_be !== 4'b1111) begin n_bad++; $display("FAIL lw_be: got %b want 1111", t_be); end
    n_cmp++; if (t_we !== 1'b0) begin n_bad++; $display("FAIL lw_we: got %b want 0", t_we); end
    n_cmp++; if (t_addr !== 32'h204) begin n_bad++; $display("FAIL lw_addr: got %h want 00000204", t_addr); end
    n_cmp++; if (t_md !== 32'h12345678) begin n_bad++; $display("FAIL lw_memdata: got %h want 12345678", t_md); end
    n_cmp++; if (t_stalls !== 2) begin n_bad++; $display("FAIL lw_stall_cycles: got %0d want 2", t_stalls); end
    clear_inputs();
    @(posedge clk); #1;
    n_cmp++; if (MemDataM !== 32'h12345678) begin n_bad++; $display("FAIL lw_hold: got %h want 12345678", MemDataM); end
    // a later store must not disturb the held read word
    run_access(1'b0, 1'b1, 2'b00, 32'h101, 32'h0000003C, 2, 32'hFFFFFFFF);
    n_cmp++; if (t_md !== 32'h12345678) begin n_bad++; $display("FAIL sb_keeps_memdata: got %h want 12345678", t_md); end
    n_cmp++; if (t_be !== 4'b0010) begin n_bad++; $display("FAIL sb1_be: got %b want 0010", t_be); end
    // MemRead and MemWrite together act as a write
    run_access(1'b1, 1'b1, 2'b11, 32'h208, 32'h0BADF00D, 1, 32'h55555555);
    n_cmp++; if (t_we !== 1'b1) begin n_bad++; $display("FAIL rdwr_we: got %b want 1", t_we); end
    n_cmp++; if (t_be !== 4'b1111) begin n_bad++; $display("FAIL sz11_be: got %b want 1111", t_be); end
    n_cmp++; if (t_md !== 32'h12345678) begin n_bad++; $display("FAIL rdwr_memdata: got %h want 12345678", t_md); end
    clear_inputs();
  endtask

  task automatic test_timeout();
    run_access(1'b1, 1'b0, 2'b10, 32'h300, 32'h0, 0, 32'h77777777);
    n_cmp++; if (t_reqs !== 16) begin n_bad++; $display("FAIL to_req_cycles: got %0d want 16", t_reqs); end
    n_cmp++; if (t_stalls !== 17) begin n_bad++; $display("FAIL to_stall_cycles: got %0d want 17", t_stalls); end
    n_cmp++; if (t_early_to !== 1'b0) begin n_bad++; $display("FAIL to_early: got %b want 0", t_early_to); end
    n_cmp++; if (t_done_to !== 1'b1) begin n_bad++; $display("FAIL to_pulse: got %b want 1", t_done_to); end
    n_cmp++; if (t_md !== 32'h0) begin n_bad++; $display("FAIL to_memdata: got %h want 0", t_md); end
    clear_inputs();
    @(posedge clk); #1;
    n_cmp++; if (bus_timeout !== 1'b0) begin n_bad++; $display("FAIL to_pulse_end: got %b want 0", bus_timeout); end
    n_cmp++; if (StallMem !== 1'b0) begin n_bad++; $display("FAIL to_stall_release: got %b want 0", StallMem); end
    // ack in the final REQ cycle beats the timeout
    run_access(1'b1, 1'b0, 2'b10, 32'h304, 32'h0, 16, 32'hCAFEF00D);
    n_cmp++; if (t_done_to !== 1'b0) begin n_bad++; $display("FAIL ackwin_pulse: got %b want 0", t_done_to); end
    n_cmp++; if (t_md !== 32'hCAFEF00D) begin n_bad++; $display("FAIL ackwin_memdata: got %h want cafef00d", t_md); end
    n_cmp++; if (t_reqs !== 16) begin n_bad++; $display("FAIL ackwin_req_cycles: got %0d want 16", t_reqs); end
    clear_inputs();
  endtask

  task automatic test_back_to_back();
    run_access(1'b1, 1'b0, 2'b10, 32'h208, 32'h0, 2, 32'h11112222);
    n_cmp++; if (t_done_req !== 1'b0) begin n_bad++; $display("FAIL b2b_done_req: got %b want 0", t_done_req); end
    n_cmp++; if (t_md !== 32'h11112222) begin n_bad++; $display("FAIL b2b_lw_memdata: got %h want 11112222", t_md); end
    run_access(1'b0, 1'b1, 2'b10, 32'h20C, 32'h33334444, 1, 32'h0);
    n_cmp++; if (t_idle_req !== 1'b0) begin n_bad++; $display("FAIL b2b_idle_req: got %b want 0", t_idle_req); end
    n_cmp++; if (t_stalls !== 2) begin n_bad++; $display("FAIL b2b_sw_stalls: got %0d want 2", t_stalls); end
    n_cmp++; if (t_addr !== 32'h20C) begin n_bad++; $display("FAIL b2b_sw_addr: got %h want 0000020c", t_addr); end
    n_cmp++; if (t_wdata !== 32'h33334444) begin n_bad++; $display("FAIL b2b_sw_wdata: got %h want 33334444", t_wdata); end
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    MemReadM = 1'b1; InstrM_2b = 2'b10; ALUResultM = 32'h400;
    @(posedge clk); #1;
    n_cmp++; if (bus_req !== 1'b1) begin n_bad++; $display("FAIL rst_mid_req_before: got %b want 1", bus_req); end
    reset = 1'b1;
    clear_inputs();
    @(posedge clk); #1;
    n_cmp++; if (bus_req !== 1'b0) begin n_bad++; $display("FAIL rst_mid_req_drop: got %b want 0", bus_req); end
    reset = 1'b0;
    bus_ack = 1'b1; bus_rdata = 32'h99999999;
    @(posedge clk); #1;
    bus_ack = 1'b0;
    n_cmp++; if (MemDataM !== 32'h0) begin n_bad++; $display("FAIL late_ack_memdata: got %h want 0", MemDataM); end
    n_cmp++; if (bus_req !== 1'b0) begin n_bad++; $display("FAIL late_ack_req: got %b want 0", bus_req); end
    n_cmp++; if (StallMem !== 1'b0) begin n_bad++; $display("FAIL late_ack_stall: got %b want 0", StallMem); end
  endtask

`ifdef DMEM_MISALIGN_TRAP_EN
  task automatic test_misalign();
    @(posedge clk); #1;
    MemReadM = 1'b1; InstrM_2b = 2'b10; ALUResultM = 32'h101;
    #1;
    n_cmp++; if (misalign_err !== 1'b1) begin n_bad++; $display("FAIL mis_err: got %b want 1", misalign_err); end
    @(posedge clk); #1;
    n_cmp++; if (bus_req !== 1'b0) begin n_bad++; $display("FAIL mis_req: got %b want 0", bus_req); end
    n_cmp++; if (StallMem !== 1'b0) begin n_bad++; $display("FAIL mis_stall: got %b want 0", StallMem); end
    n_cmp++; if (misalign_err !== 1'b0) begin n_bad++; $display("FAIL mis_err_pulse: got %b want 0", misalign_err); end
    n_cmp++; if (MemDataM !== 32'h0) begin n_bad++; $display("FAIL mis_memdata: got %h want 0", MemDataM); end
    clear_inputs();
  endtask
`endif

  initial begin
    test_reset();
    test_store();
    test_load();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
`ifdef DMEM_MISALIGN_TRAP_EN
    test_misalign();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_dmem_port
`default_nettype wire
